// File: rtl/my_send_to_fx2lp_pkt.sv
// my_send_to_fx2lp_pkt: Avalon-ST sink to FX2LP slave-FIFO byte writer with PKTEND commit on EOP or idle timeout.
module my_send_to_fx2lp_pkt #(
  parameter int         DATA_W       = 32,
  parameter bit         LSB_FIRST    = 1'b1,
  parameter logic [1:0] FIFO_ADDR    = 2'b00,
  parameter int         PKT_BYTES    = 512,
  parameter int         IDLE_TIMEOUT = 4096
) (
  input  logic              csi_clk,
  input  logic              rsi_reset,
  input  logic [DATA_W-1:0] asi_in0_data,
  input  logic              asi_in0_valid,
  input  logic              asi_in0_endofpacket,
  output logic              asi_in0_ready,
  output logic [7:0]        coe_fx2lp_fd,
  output logic              coe_fx2lp_slwr_n,
  output logic              coe_fx2lp_pktend_n,
  input  logic [2:0]        coe_fx2lp_flag_n,
  output logic              coe_fx2lp_slrd_n,
  output logic              coe_fx2lp_sloe_n,
  output logic [1:0]        coe_fx2lp_fifoadr
);
  localparam int N = DATA_W / 8;
  localparam int IW = $clog2(N) + 1;
  localparam int PW = $clog2(PKT_BYTES);
  localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam bit TO_EN = IDLE_TIMEOUT > 0;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [TW-1:0] TMAX = TW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, PKTEND} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              eop_q, eop_d;
  logic [7:0]        fd_q, fd_d;
  logic              slwr_n_q, slwr_n_d;
  logic              pktend_n_q, pktend_n_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic [TW-1:0]     idle_q, idle_d;
  logic [PW-1:0]     pkt_inc;
  logic              timeout_hit, accept, last;
  logic              unused_flags;

  function automatic logic [7:0] byte_at(input logic [DATA_W-1:0] w, input logic [IW-1:0] i);
    logic [IW-1:0] k;
    k = LSB_FIRST ? i : LAST - i;
    return w[{k, 3'b000} +: 8];
  endfunction

  assign timeout_hit = TO_EN && state_q == IDLE && idle_q == TMAX;
  assign asi_in0_ready = state_q == IDLE && coe_fx2lp_flag_n[1] && !timeout_hit;
  assign accept = asi_in0_valid && asi_in0_ready;
  assign pkt_inc = pkt_cnt_q + PW'(1);
  assign unused_flags = coe_fx2lp_flag_n[2] ^ coe_fx2lp_flag_n[0];

  assign coe_fx2lp_fd = fd_q;
  assign coe_fx2lp_slwr_n = slwr_n_q;
  assign coe_fx2lp_pktend_n = pktend_n_q;
  assign coe_fx2lp_slrd_n = 1'b1;
  assign coe_fx2lp_sloe_n = 1'b1;
  assign coe_fx2lp_fifoadr = FIFO_ADDR;

  always_comb begin
    state_d = state_q;
    word_d = word_q;
    eop_d = eop_q;
    fd_d = fd_q;
    slwr_n_d = 1'b1;
    pktend_n_d = 1'b1;
    idx_d = idx_q;
    pkt_cnt_d = pkt_cnt_q;
    idle_d = '0;
    last = 1'b0;
    case (state_q)
      IDLE:
        if (accept) begin
          word_d = asi_in0_data;
          eop_d = asi_in0_endofpacket;
          fd_d = byte_at(asi_in0_data, '0);
          slwr_n_d = 1'b0;
          idx_d = IW'(1);
          pkt_cnt_d = pkt_inc;
          state_d = SEND;
          last = N == 1;
        end else if (timeout_hit) begin
          state_d = PKTEND;
          pktend_n_d = 1'b0;
        end else if (TO_EN && pkt_cnt_q != '0) begin
          idle_d = idle_q + TW'(1);
        end
      SEND:
        if (coe_fx2lp_flag_n[1]) begin
          fd_d = byte_at(word_q, idx_q);
          slwr_n_d = 1'b0;
          idx_d = idx_q + IW'(1);
          pkt_cnt_d = pkt_inc;
          last = idx_q == LAST;
        end
      // Entered from a final byte the strobe is still low, so the pulse waits one cycle.
      PKTEND:
        if (pktend_n_q) begin
          pktend_n_d = 1'b0;
        end else begin
          pkt_cnt_d = '0;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
    if (last) state_d = (eop_d && pkt_inc != '0) ? PKTEND : IDLE;
  end

  always_ff @(negedge csi_clk) begin
    if (rsi_reset) begin
      state_q <= IDLE;
      word_q <= '0;
      eop_q <= 1'b0;
      fd_q <= '0;
      slwr_n_q <= 1'b1;
      pktend_n_q <= 1'b1;
      idx_q <= '0;
      pkt_cnt_q <= '0;
      idle_q <= '0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      eop_q <= eop_d;
      fd_q <= fd_d;
      slwr_n_q <= slwr_n_d;
      pktend_n_q <= pktend_n_d;
      idx_q <= idx_d;
      pkt_cnt_q <= pkt_cnt_d;
      idle_q <= idle_d;
    end
  end
endmodule

// File: tb/tb_my_send_to_fx2lp_pkt.sv
// tb_my_send_to_fx2lp_pkt: bench comparing the FX2LP byte/PKTEND event stream against a packet-level model.
module tb_my_send_to_fx2lp_pkt;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] data = '0;
  logic valid = 1'b0, eop = 1'b0, ready;
  logic [7:0] fd;
  logic slwr_n, pktend_n, slrd_n, sloe_n;
  logic [2:0] flag_n = 3'b111;
  logic [1:0] fifoadr;
  int n_cmp = 0, n_bad = 0, cyc_n = 0, pkt_m = 0;
  bit mon_en = 1'b0, prev_f = 1'b1;
  int exp_q[$];
  int stb[$];
  int pkc[$];

  always #5 clk = ~clk;

  my_send_to_fx2lp_pkt #(.DATA_W(32), .LSB_FIRST(1'b1), .FIFO_ADDR(2'b00), .PKT_BYTES(512), .IDLE_TIMEOUT(16)) dut (
    .csi_clk(clk), .rsi_reset(rst),
    .asi_in0_data(data), .asi_in0_valid(valid), .asi_in0_endofpacket(eop), .asi_in0_ready(ready),
    .coe_fx2lp_fd(fd), .coe_fx2lp_slwr_n(slwr_n), .coe_fx2lp_pktend_n(pktend_n), .coe_fx2lp_flag_n(flag_n),
    .coe_fx2lp_slrd_n(slrd_n), .coe_fx2lp_sloe_n(sloe_n), .coe_fx2lp_fifoadr(fifoadr)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // 256 stands for a PKTEND pulse in the expected event stream.
  task automatic model_word(input logic [31:0] d, input logic e);
    for (int i = 0; i < 4; i++) exp_q.push_back(int'(d[8*i +: 8]));
    pkt_m = (pkt_m + 4) % 512;
    if (e && pkt_m != 0) begin
      exp_q.push_back(256);
      pkt_m = 0;
    end
  endtask

  task automatic ev(input int v);
    int e;
    if (exp_q.size() == 0) check("evt", v, -1);
    else begin
      e = exp_q.pop_front();
      check("evt", v, e);
    end
  endtask

  always @(posedge clk) if (mon_en) begin
    cyc_n++;
    check("excl", longint'(!slwr_n && !pktend_n), 0);
    if (!slwr_n) begin
      stb.push_back(cyc_n);
      ev(int'(fd));
    end
    if (!pktend_n) begin
      pkc.push_back(cyc_n);
      ev(256);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic e, input logic f, output logic acc, output logic rdy);
    @(posedge clk);
    #1;
    valid = v;
    data = d;
    eop = e;
    flag_n = f ? 3'b111 : 3'b101;
    #1;
    rdy = ready;
    acc = v && ready;
    if (acc) model_word(d, e);
  endtask

  task automatic idle(input int n);
    logic a, r;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b1, a, r);
  endtask

  task automatic send(input logic [31:0] d, input logic e);
    logic a, r;
    int k;
    k = 0;
    do begin
      cyc(1'b1, d, e, 1'b1, a, r);
      k++;
    end while (!a && k < 40);
    if (!a) check("send_acc", 0, 1);
  endtask

  function automatic logic next_flag();
    prev_f = prev_f ? ($urandom_range(0, 4) != 0) : 1'b1;
    return prev_f;
  endfunction

  initial begin
    logic a, r, f, e;
    logic [31:0] d;
    int n0, p0, n, k, gap;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    check("rst_fd", fd, 0);
    check("rst_slwr", slwr_n, 1);
    check("rst_pktend", pktend_n, 1);
    check("rst_ready", ready, 1);
    check("const_adr", fifoadr, 0);
    check("const_rd_oe", {slrd_n, sloe_n}, 3);

    cyc(1'b1, 32'h44332211, 1'b0, 1'b1, a, r);
    check("t1_acc", a, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b1, a, r);
      check("t1_rdy", r, longint'(i == 3));
    end
    check("t1_cnt", stb.size(), 4);
    if (stb.size() == 4) check("t1_span", stb[3] - stb[0], 3);

    exp_q.push_back(256);
    pkt_m = 0;
    n0 = pkc.size();
    for (int i = 0; i < 40 && pkc.size() == n0; i++) cyc(1'b0, '0, 1'b0, 1'b1, a, r);
    if (pkc.size() == n0) check("t5_pulse", 0, 1);
    else begin
      check("t5_delay", pkc[n0] - stb[stb.size()-1], 17);
      check("t5_rdy", r, 0);
      idle(1);
      check("t5_len", pktend_n, 1);
    end

    n0 = stb.size();
    p0 = pkc.size();
    for (int i = 0; i < 128; i++) send($urandom(), 1'b0);
    idle(30);
    check("t2_cnt", stb.size() - n0, 512);
    if (stb.size() - n0 >= 512) check("t2_gap", stb[n0+511] - stb[n0], 511);
    check("t2_nopkt", pkc.size(), p0);

    cyc(1'b1, 32'hDDCCBBAA, 1'b0, 1'b1, a, r);
    check("t3_acc", a, 1);
    cyc(1'b0, '0, 1'b0, 1'b1, a, r);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, '0, 1'b0, i == 5, a, r);
      if (i > 0) begin
        check("t3_hold_slwr", slwr_n, 1);
        check("t3_hold_fd", fd, 8'hBB);
      end
    end
    idle(2);
    n = stb.size();
    check("t3_gap_ab", stb[n-3] - stb[n-4], 1);
    check("t3_gap_bc", stb[n-2] - stb[n-3], 6);
    check("t3_gap_cd", stb[n-1] - stb[n-2], 1);

    n0 = stb.size();
    p0 = pkc.size();
    send(32'h0403_0201, 1'b0);
    send(32'h0807_0605, 1'b0);
    send(32'h0c0b_0a09, 1'b1);
    for (int i = 0; i < 10 && pkc.size() == p0; i++) cyc(1'b0, '0, 1'b0, 1'b1, a, r);
    check("t4_cnt", stb.size() - n0, 12);
    if (stb.size() - n0 == 12) check("t4_span", stb[n0+11] - stb[n0], 11);
    if (pkc.size() == p0) check("t4_pulse", 0, 1);
    else begin
      check("t4_delay", pkc[p0] - stb[stb.size()-1], 1);
      check("t4_rdy_pulse", r, 0);
      cyc(1'b0, '0, 1'b0, 1'b1, a, r);
      check("t4_rdy_back", r, 1);
    end

    cyc(1'b1, 32'h8765_4321, 1'b0, 1'b1, a, r);
    check("t6_acc", a, 1);
    idle(2);
    rst = 1'b1;
    exp_q.delete();
    pkt_m = 0;
    cyc(1'b0, '0, 1'b0, 1'b1, a, r);
    check("t6_slwr", slwr_n, 1);
    check("t6_fd", fd, 0);
    check("t6_pktend", pktend_n, 1);
    check("t6_rdy", r, 1);
    rst = 1'b0;
    p0 = pkc.size();
    for (int i = 0; i < 128; i++) send($urandom(), i == 127);
    idle(30);
    check("t6_wrap_nopkt", pkc.size(), p0);

    for (int w = 0; w < 300; w++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        f = next_flag();
        cyc(1'b0, '0, 1'b0, f, a, r);
      end
      d = $urandom();
      e = $urandom_range(0, 5) == 0;
      k = 0;
      do begin
        f = next_flag();
        cyc(1'b1, d, e, f, a, r);
        k++;
      end while (!a && k < 40);
      if (!a) check("rnd_acc", 0, 1);
    end
    if (pkt_m != 0) begin
      exp_q.push_back(256);
      pkt_m = 0;
    end
    idle(40);
    check("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
